exu_longpwbck_mc: RTL

Multi-channel, registered long-pipe write-back arbiter. Accepts write-back requests from NCH long-pipe units (LSU, future MULDIV/FPU, ...). Retires strictly in OITF order: only the channel whose itag equals the OITF retire pointer is served. Buffers the result in a one-entry output register before the final write-back port, which cuts the combinational path from the OITF to the regfile arbiter.

---
 rtl/exu_longpwbck_mc_if.sv | 40 ++++
 rtl/exu_longpwbck_mc.sv | 95 +++++++++
 2 files changed

// File: rtl/exu_longpwbck_mc_if.sv
// Bus bundle for exu_longpwbck_mc: per-channel write-back requests, OITF retire view, final write-back port.
// slave = arbiter side, master = the surrounding pipeline (sources, OITF, regfile arbiter).
interface exu_longpwbck_mc_if #(
  parameter int NCH     = 2,
  parameter int XLEN    = 32,
  parameter int ITAG_W  = 2,
  parameter int RFIDX_W = 5
);
  logic [NCH-1:0]         ch_wbck_i_valid;
  logic [NCH-1:0]         ch_wbck_i_ready;
  logic [NCH*XLEN-1:0]    ch_wbck_i_data;
  logic [NCH*ITAG_W-1:0]  ch_wbck_i_itag;

  logic                   oitf_empty;
  logic [ITAG_W-1:0]      oitf_ret_ptr;
  logic                   oitf_ret_rdwen;
  logic [RFIDX_W-1:0]     oitf_ret_rdidx;
  logic                   oitf_ret_ena;

  logic                   longp_wbck_o_valid;
  logic                   longp_wbck_o_ready;
  logic [XLEN-1:0]        longp_wbck_o_data;
  logic [RFIDX_W-1:0]     longp_wbck_o_rdidx;

  modport slave (
    input  ch_wbck_i_valid, ch_wbck_i_data, ch_wbck_i_itag,
    input  oitf_empty, oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdidx,
    input  longp_wbck_o_ready,
    output ch_wbck_i_ready, oitf_ret_ena,
    output longp_wbck_o_valid, longp_wbck_o_data, longp_wbck_o_rdidx
  );

  modport master (
    output ch_wbck_i_valid, ch_wbck_i_data, ch_wbck_i_itag,
    output oitf_empty, oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdidx,
    output longp_wbck_o_ready,
    input  ch_wbck_i_ready, oitf_ret_ena,
    input  longp_wbck_o_valid, longp_wbck_o_data, longp_wbck_o_rdidx
  );
endinterface

// File: rtl/exu_longpwbck_mc.sv
// Multi-channel long-pipe write-back arbiter: retires in OITF order through a one-entry output buffer.
// Optional macro LONGPWBCK_BYPASS_EN presents a result combinationally when the buffer is empty.
module exu_longpwbck_mc #(
  parameter int NCH     = 2,
  parameter int XLEN    = 32,
  parameter int ITAG_W  = 2,
  parameter int RFIDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  exu_longpwbck_mc_if.slave    wb
);

  logic [NCH-1:0]            hit;
  logic [NCH-1:0]            sel;
  logic [NCH-1:0][XLEN-1:0]  ch_data;
  logic [XLEN-1:0]           win_data;
  logic                      taken;

  logic                      buf_vld_q, buf_vld_d;
  logic [XLEN-1:0]           buf_data_q, buf_data_d;
  logic [RFIDX_W-1:0]        buf_rdidx_q, buf_rdidx_d;

  logic                      buf_free;
  logic                      retire;
  logic                      load;
  logic                      byp;
  logic                      buf_ld;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch_data[k] = wb.ch_wbck_i_data[k*XLEN +: XLEN];
    assign hit[k]     = ~wb.oitf_empty &
                        (wb.ch_wbck_i_itag[k*ITAG_W +: ITAG_W] == wb.oitf_ret_ptr);
  end

  // Priority is taken on the itag hit alone, so a channel's ready never
  // depends on another channel's valid.
  always_comb begin
    sel      = '0;
    win_data = '0;
    taken    = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (hit[k] && !taken) begin
        sel[k]   = wb.ch_wbck_i_valid[k];
        win_data = ch_data[k];
      end
      taken = taken | hit[k];
    end
  end

  assign buf_free           = ~buf_vld_q | wb.longp_wbck_o_ready;
  assign wb.ch_wbck_i_ready = sel & {NCH{(wb.oitf_ret_rdwen ? buf_free : 1'b1)}};
  assign retire             = |(wb.ch_wbck_i_valid & wb.ch_wbck_i_ready);
  assign wb.oitf_ret_ena    = retire;
  assign load               = retire & wb.oitf_ret_rdwen;

`ifdef LONGPWBCK_BYPASS_EN
  assign byp = ~buf_vld_q & load;
`else
  assign byp = 1'b0;
`endif

  // A bypassed result accepted in the same cycle never enters the buffer.
  assign buf_ld = load & ~(byp & wb.longp_wbck_o_ready);

  always_comb begin
    buf_vld_d   = buf_vld_q;
    buf_data_d  = buf_data_q;
    buf_rdidx_d = buf_rdidx_q;
    if (buf_ld) begin
      buf_vld_d   = 1'b1;
      buf_data_d  = win_data;
      buf_rdidx_d = wb.oitf_ret_rdidx;
    end else if (buf_vld_q && wb.longp_wbck_o_ready) begin
      buf_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld_q   <= 1'b0;
      buf_data_q  <= '0;
      buf_rdidx_q <= '0;
    end else begin
      buf_vld_q   <= buf_vld_d;
      buf_data_q  <= buf_data_d;
      buf_rdidx_q <= buf_rdidx_d;
    end
  end

  assign wb.longp_wbck_o_valid = buf_vld_q | byp;
  assign wb.longp_wbck_o_data  = byp ? win_data          : buf_data_q;
  assign wb.longp_wbck_o_rdidx = byp ? wb.oitf_ret_rdidx : buf_rdidx_q;

endmodule
